// File: rtl/tone_frame_buffer.sv
// tone_frame_buffer: frame store and sequencer acting as the memory responder
// for the global tone-mapping engine. A frame is loaded from the upstream
// stream, the engine is started and served, then the results are streamed out
// as saturated pixels and the engine is reset for the next frame.

module tone_frame_buffer #(
  parameter int D_W    = 16,
  parameter int D_HW   = 8,
  parameter int ADDR_W = 16,
  parameter int NUM_W  = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic [NUM_W-1:0]  i_total_pixels,
  input  logic              i_in_valid,
  input  logic [D_W-1:0]    i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [D_HW-1:0]   o_out_data,
  input  logic              i_out_ready,
  output logic              o_eng_start,
  output logic              o_eng_rst_n,
  input  logic              i_eng_fin,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic [D_W-1:0]    i_eng_wdata,
  input  logic              i_eng_wen,
  output logic [D_W-1:0]    o_eng_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDR_W or 2^NUM_W, so comparisons use one extra bit.
  localparam logic [NUM_W:0]  LP_DEPTH_N = (NUM_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_DEPTH_A = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [D_W-1:0]    r_mem [DEPTH];
  logic [NUM_W-1:0]  r_count;
  logic [NUM_W-1:0]  r_wrPtr;
  logic [NUM_W-1:0]  r_rdPtr;
  logic [D_HW-1:0]   r_outData;
  logic              r_outValid;
  logic              r_engStart;
  logic              r_done;
  logic              r_engClr;

  logic              w_sizeOk;
  logic              w_inFire;
  logic              w_addrOk;
  logic [NUM_W-1:0]  w_lastIdx;
  logic [D_W-1:0]    w_rdWord;
  logic [D_W-1:0]    w_drainWord;
  logic [D_HW-1:0]   w_satWord;
  logic              w_memWe;
  logic [AW-1:0]     w_memIdx;
  logic [D_W-1:0]    w_memWd;

  assign w_sizeOk    = (i_total_pixels != '0) && ({1'b0, i_total_pixels} <= LP_DEPTH_N);
  assign o_in_ready  = rst_n && (((r_state == S_IDLE) && w_sizeOk) || (r_state == S_LOAD));
  assign o_err       = rst_n && (r_state == S_IDLE) && !w_sizeOk;
  assign w_inFire    = o_in_ready && i_in_valid;
  assign w_lastIdx   = r_count - NUM_W'(1);

  // Out-of-range engine addresses read as zero; read sees pre-write data.
  assign w_addrOk    = {1'b0, i_eng_addr} < LP_DEPTH_A;
  assign w_rdWord    = w_addrOk ? r_mem[i_eng_addr[AW-1:0]] : '0;
  assign o_eng_rdata = rst_n ? w_rdWord : '0;

  // Words at or above 2^D_HW clamp to all ones, covering full-scale results.
  assign w_drainWord = r_mem[r_rdPtr[AW-1:0]];
  assign w_satWord   = (|w_drainWord[D_W-1:D_HW]) ? '1 : w_drainWord[D_HW-1:0];

  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_eng_start = r_engStart;
  assign o_done      = r_done;
  assign o_eng_rst_n = rst_n & ~r_engClr;
  assign o_busy      = (r_state != S_IDLE);

  // Select the single memory write source: upstream load or engine in S_RUN.
  always_comb begin
    w_memWe  = 1'b0;
    w_memIdx = '0;
    w_memWd  = i_in_data;
    if (w_inFire) begin
      w_memWe  = 1'b1;
      w_memIdx = (r_state == S_LOAD) ? r_wrPtr[AW-1:0] : '0;
    end else if ((r_state == S_RUN) && i_eng_wen && w_addrOk) begin
      w_memWe  = 1'b1;
      w_memIdx = i_eng_addr[AW-1:0];
      w_memWd  = i_eng_wdata;
    end
  end

  // Frame store write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_memWe) begin
      r_mem[w_memIdx] <= w_memWd;
    end
  end

  // Frame sequencer: load, start, serve engine, drain, clear engine.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_engStart <= 1'b0;
      r_done     <= 1'b0;
      r_engClr   <= 1'b0;
    end else begin
      r_engStart <= 1'b0;
      r_done     <= 1'b0;
      r_engClr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_inFire) begin
            r_count <= i_total_pixels;
            r_wrPtr <= NUM_W'(1);
            if (i_total_pixels == NUM_W'(1)) begin
              r_state    <= S_START;
              r_engStart <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_inFire) begin
            r_wrPtr <= r_wrPtr + NUM_W'(1);
            if (r_wrPtr == w_lastIdx) begin
              r_state    <= S_START;
              r_engStart <= 1'b1;
            end
          end
        end
        S_START: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_eng_fin) begin
            r_state    <= S_DRAIN;
            r_rdPtr    <= '0;
            r_outValid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_outValid) begin
            if (i_out_ready) begin
              r_outValid <= 1'b0;
              if (r_rdPtr == w_lastIdx) begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_engClr <= 1'b1;
              end else begin
                r_rdPtr <= r_rdPtr + NUM_W'(1);
              end
            end
          end else begin
            r_outData  <= w_satWord;
            r_outValid <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_frame_buffer.sv
// tb_tone_frame_buffer: directed bench for tone_frame_buffer with a small
// engine responder, a queue-based pixel model and a per-cycle compare process.

module tb_tone_frame_buffer;

  localparam int D_W    = 16;
  localparam int D_HW   = 8;
  localparam int ADDR_W = 16;
  localparam int NUM_W  = 16;
  localparam int DEPTH  = 1024;

  logic              i_clk = 1'b0;
  logic              rst_n;
  logic [NUM_W-1:0]  i_total_pixels;
  logic              i_in_valid;
  logic [D_W-1:0]    i_in_data;
  logic              o_in_ready;
  logic              o_out_valid;
  logic [D_HW-1:0]   o_out_data;
  logic              i_out_ready;
  logic              o_eng_start;
  logic              o_eng_rst_n;
  logic              i_eng_fin;
  logic [ADDR_W-1:0] i_eng_addr;
  logic [D_W-1:0]    i_eng_wdata;
  logic              i_eng_wen;
  logic [D_W-1:0]    o_eng_rdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int nChecks = 0;
  int nFails  = 0;
  int expQ[$];
  int capQ[$];
  int inWords[DEPTH];
  int wTab[DEPTH];
  int startCnt = 0;
  int doneCnt = 0;
  int engLowCnt = 0;
  int hsCnt = 0;
  bit prevHold = 1'b0;
  logic [31:0] prevData = '0;

  tone_frame_buffer #(
    .D_W(D_W), .D_HW(D_HW), .ADDR_W(ADDR_W), .NUM_W(NUM_W), .DEPTH(DEPTH)
  ) dut (
    .i_clk          (i_clk),
    .rst_n          (rst_n),
    .i_total_pixels (i_total_pixels),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .o_out_valid    (o_out_valid),
    .o_out_data     (o_out_data),
    .i_out_ready    (i_out_ready),
    .o_eng_start    (o_eng_start),
    .o_eng_rst_n    (o_eng_rst_n),
    .i_eng_fin      (i_eng_fin),
    .i_eng_addr     (i_eng_addr),
    .i_eng_wdata    (i_eng_wdata),
    .i_eng_wen      (i_eng_wen),
    .o_eng_rdata    (o_eng_rdata),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Clamp to the pixel range: anything at or above 2^D_HW becomes all ones.
  function automatic int satModel(input int v);
    return (v >= (1 << D_HW)) ? ((1 << D_HW) - 1) : v;
  endfunction

  // What the engine leaves in mem[idx] for each engine behaviour.
  function automatic int engModel(input int mode, input int idx);
    case (mode)
      0:       return (inWords[idx] + 1) % 65536;
      1:       return inWords[idx];
      default: return wTab[idx];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkCap(input string name, input int idx, input int value);
    checkOutput(name, (idx < capQ.size()) ? 32'(capQ[idx]) : 32'hFFFF_FFFF, 32'(value));
  endtask

  // Per-cycle compare against the pixel model, away from the active edge.
  always @(negedge i_clk) begin
    if (!rst_n) begin
      prevHold = 1'b0;
      checkOutput("rst_out_valid", 32'(o_out_valid), 0);
      checkOutput("rst_busy", 32'(o_busy), 0);
      checkOutput("rst_eng_rst_n", 32'(o_eng_rst_n), 0);
    end else begin
      if (prevHold) begin
        checkOutput("hold_valid", 32'(o_out_valid), 1);
        checkOutput("hold_data", 32'(o_out_data), prevData);
      end
      if (o_out_valid && i_out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_pixel", 32'(o_out_data), 32'hFFFF_FFFF);
        end else begin
          checkOutput("pixel", 32'(o_out_data), 32'(expQ.pop_front()));
        end
        capQ.push_back(int'(o_out_data));
        hsCnt++;
      end
      prevHold = o_out_valid && !i_out_ready;
      prevData = 32'(o_out_data);
      if (o_eng_start) startCnt++;
      if (o_done) doneCnt++;
      if (!o_eng_rst_n) engLowCnt++;
      checkOutput("eng_rst_vs_done", 32'(o_eng_rst_n), 32'(!o_done));
    end
  end

  // Engine responder: wait for start, touch addresses 0..n-1, raise fin.
  task automatic runEngine(input int n, input int mode, input bit oob);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge i_clk);
      seen = o_eng_start;
    end
    checkOutput("eng_start_seen", 32'(seen), 1);
    if (!seen) return;
    @(posedge i_clk); #1;
    if (oob) begin
      i_eng_addr = ADDR_W'(1200); i_eng_wdata = 16'h1111; i_eng_wen = 1'b1;
      #1 checkOutput("oob_rd_1200", 32'(o_eng_rdata), 0);
      @(posedge i_clk); #1;
      i_eng_addr = ADDR_W'(1025); i_eng_wdata = 16'h2222;
      #1 checkOutput("oob_rd_1025", 32'(o_eng_rdata), 0);
      @(posedge i_clk); #1;
      i_eng_wen = 1'b0; i_eng_addr = ADDR_W'(1200);
      #1 checkOutput("oob_rd_after_wr", 32'(o_eng_rdata), 0);
    end
    for (int a = 0; a < n; a++) begin
      i_eng_addr = ADDR_W'(a);
      #1 checkOutput("eng_rdata", 32'(o_eng_rdata), 32'(inWords[a]));
      case (mode)
        0:       i_eng_wdata = o_eng_rdata + 16'd1;
        1:       i_eng_wdata = o_eng_rdata;
        default: i_eng_wdata = D_W'(wTab[a]);
      endcase
      i_eng_wen = 1'b1;
      @(posedge i_clk); #1;
    end
    i_eng_wen = 1'b0;
    i_eng_fin = 1'b1;
  endtask

  // One frame: load, engine pass, drain; optionally abort with reset mid-drain.
  task automatic applyStimulus(input int n, input int mode, input bit rnd, input bit oob,
                               input bit loadWr, input int abortAfter);
    bit acc;
    bit fin;
    bit clr;
    expQ.delete();
    capQ.delete();
    startCnt = 0; doneCnt = 0; engLowCnt = 0; hsCnt = 0;
    for (int i = 0; i < n; i++) expQ.push_back(satModel(engModel(mode, i)));
    i_out_ready = 1'b0;
    if (loadWr) begin
      i_eng_wen = 1'b1; i_eng_addr = '0; i_eng_wdata = D_W'(999);
    end
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = D_W'(inWords[i]);
      if (i == 0) i_total_pixels = NUM_W'(n);
      for (int c = 0; c < 20 && !acc; c++) begin
        @(negedge i_clk);
        acc = o_in_ready;
        @(posedge i_clk); #1;
      end
      if (!acc) begin
        checkOutput("load_accept", 0, 1);
        i_in_valid = 1'b0;
        i_eng_wen  = 1'b0;
        return;
      end
      if (i == 0) i_total_pixels = '0;
    end
    i_in_valid = 1'b0;
    i_eng_wen  = 1'b0;
    checkOutput("busy_after_load", 32'(o_busy), 1);
    runEngine(n, mode, oob);
    fin = 1'b0;
    for (int c = 0; c < 8 * n + 50 && !fin; c++) begin
      i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abortAfter > 0 && hsCnt >= abortAfter) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(o_out_valid), 0);
        checkOutput("abort_out_data", 32'(o_out_data), 0);
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_done", 32'(o_done), 0);
        checkOutput("abort_eng_start", 32'(o_eng_start), 0);
        checkOutput("abort_eng_rst_n", 32'(o_eng_rst_n), 0);
        checkOutput("abort_in_ready", 32'(o_in_ready), 0);
        checkOutput("abort_err", 32'(o_err), 0);
        checkOutput("abort_pixels", 32'(capQ.size()), 32'(abortAfter));
        i_eng_fin = 1'b0;
        i_out_ready = 1'b0;
        expQ.delete();
        repeat (2) @(posedge i_clk);
        #1 rst_n = 1'b1;
        @(posedge i_clk); #1;
        return;
      end
      @(negedge i_clk);
      if (o_done) fin = 1'b1;
      clr = !o_eng_rst_n;
      @(posedge i_clk); #1;
      if (clr) i_eng_fin = 1'b0;
    end
    i_out_ready = 1'b0;
    checkOutput("frame_done_seen", 32'(fin), 1);
    checkOutput("start_pulses", 32'(startCnt), 1);
    checkOutput("done_pulses", 32'(doneCnt), 1);
    checkOutput("eng_rst_low_cycles", 32'(engLowCnt), 1);
    checkOutput("pixels_left", 32'(expQ.size()), 0);
    checkOutput("pixel_count", 32'(capQ.size()), 32'(n));
    checkOutput("busy_after_done", 32'(o_busy), 0);
    checkOutput("fin_released", 32'(i_eng_fin), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i_total_pixels = NUM_W'(4);
    i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
    i_eng_fin = 1'b0; i_eng_addr = '0; i_eng_wdata = '0; i_eng_wen = 1'b0;

    // Reset state
    #2;
    checkOutput("reset_in_ready", 32'(o_in_ready), 0);
    checkOutput("reset_eng_rst_n", 32'(o_eng_rst_n), 0);
    checkOutput("reset_err", 32'(o_err), 0);
    checkOutput("reset_done", 32'(o_done), 0);
    checkOutput("reset_start", 32'(o_eng_start), 0);
    repeat (2) @(posedge i_clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("idle_in_ready", 32'(o_in_ready), 1);
    checkOutput("idle_eng_rst_n", 32'(o_eng_rst_n), 1);
    checkOutput("idle_err", 32'(o_err), 0);

    // Basic frame, engine adds one
    inWords[0] = 10; inWords[1] = 20; inWords[2] = 30; inWords[3] = 40;
    applyStimulus(4, 0, 1'b0, 1'b0, 1'b0, 0);
    checkCap("basic_px0", 0, 11);
    checkCap("basic_px1", 1, 21);
    checkCap("basic_px2", 2, 31);
    checkCap("basic_px3", 3, 41);

    // Illegal sizes hold the block in idle
    i_total_pixels = '0; i_in_valid = 1'b1; i_in_data = D_W'(55);
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("n0_err", 32'(o_err), 1);
      checkOutput("n0_in_ready", 32'(o_in_ready), 0);
      checkOutput("n0_busy", 32'(o_busy), 0);
    end
    @(posedge i_clk); #1 i_total_pixels = NUM_W'(DEPTH + 1);
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("nbig_err", 32'(o_err), 1);
      checkOutput("nbig_in_ready", 32'(o_in_ready), 0);
      checkOutput("nbig_busy", 32'(o_busy), 0);
    end
    @(posedge i_clk); #1 i_in_valid = 1'b0; i_total_pixels = NUM_W'(DEPTH);
    #1;
    checkOutput("ndepth_err", 32'(o_err), 0);
    checkOutput("ndepth_in_ready", 32'(o_in_ready), 1);

    // Saturation of engine results
    inWords[0] = 1; inWords[1] = 2; inWords[2] = 3; inWords[3] = 4;
    wTab[0] = 256; wTab[1] = 300; wTab[2] = 255; wTab[3] = 128;
    applyStimulus(4, 2, 1'b0, 1'b0, 1'b0, 0);
    checkCap("sat_px0", 0, 255);
    checkCap("sat_px1", 1, 255);
    checkCap("sat_px2", 2, 255);
    checkCap("sat_px3", 3, 128);

    // Random downstream backpressure
    for (int i = 0; i < 8; i++) inWords[i] = i * 13 + 3;
    applyStimulus(8, 0, 1'b1, 1'b0, 1'b0, 0);

    // Out-of-range engine accesses and writes attempted during load
    inWords[0] = 100; inWords[1] = 200; inWords[2] = 300; inWords[3] = 400;
    applyStimulus(4, 1, 1'b0, 1'b1, 1'b1, 0);
    checkCap("oob_px0", 0, 100);
    checkCap("oob_px1", 1, 200);
    checkCap("oob_px2", 2, 255);
    checkCap("oob_px3", 3, 255);

    // Reset mid-drain, then a clean frame
    inWords[0] = 1; inWords[1] = 2; inWords[2] = 3; inWords[3] = 4;
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, 2);
    checkCap("abort_px0", 0, 1);
    checkCap("abort_px1", 1, 2);
    inWords[0] = 5; inWords[1] = 6;
    applyStimulus(2, 1, 1'b0, 1'b0, 1'b0, 0);
    checkCap("recover_px0", 0, 5);
    checkCap("recover_px1", 1, 6);

    // Full-depth frame
    for (int i = 0; i < DEPTH; i++) inWords[i] = (i * 37) % 600;
    applyStimulus(DEPTH, 0, 1'b0, 1'b0, 1'b0, 0);
    checkCap("full_px1", 1, 38);
    checkCap("full_px7", 7, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
